// File: rtl/md_counter_checker_4bit.sv
// Purpose: checks that a counter stream follows the up/down sequence; locks, then counts deviations.
// Latency: every output is registered one clk after the sampling edge; locks after 1 capture + LOCK_CNT matches.
// Backpressure: none; a sample is taken only on edges with en=1, and clr overrides en.
module md_counter_checker_4bit #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 dir,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  // good_cnt must be able to reach LOCK_CNT itself
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [WIDTH-1:0]     CNT_ONE  = WIDTH'(1);
  localparam logic [GOOD_W-1:0]    GOOD_ONE = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    LOCK_VAL = GOOD_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [GOOD_W-1:0]      good_cnt;
  logic [GOOD_W-1:0]      good_nxt;
  logic [GOOD_W-1:0]      good_inc;
  logic [WIDTH-1:0]       expected_nxt;
  logic [ERR_CNT_W-1:0]   err_count_nxt;
  logic [ERR_CNT_W-1:0]   err_count_sat;
  logic                   err_pulse_nxt;
  logic [WIDTH-1:0]       pred_from_in;
  logic [WIDTH-1:0]       pred_from_exp;
  logic                   match;

  // Successor of a value in the direction selected on this edge; wraps modulo 2^WIDTH
  assign pred_from_in  = dir ? (count_in - CNT_ONE) : (count_in + CNT_ONE);
  assign pred_from_exp = dir ? (expected - CNT_ONE) : (expected + CNT_ONE);
  assign match         = (count_in == expected);
  assign good_inc      = good_cnt + GOOD_ONE;
  assign err_count_sat = (err_count == {ERR_CNT_W{1'b1}}) ? err_count : (err_count + ERR_ONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: clr wins over en; a mismatch while locked always drops back to acquisition
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = UNLOCKED;
    end else if (en) begin
      case (state)
        UNLOCKED: state_nxt = ACQUIRE;
        ACQUIRE:  if (match && (good_inc == LOCK_VAL)) state_nxt = LOCKED;
        LOCKED:   if (!match) state_nxt = ACQUIRE;
        default:  state_nxt = UNLOCKED;
      endcase
    end
  end

  // Output/datapath next values; a mismatching sample becomes the new reference
  always_comb begin
    expected_nxt  = expected;
    good_nxt      = good_cnt;
    err_count_nxt = err_count;
    err_pulse_nxt = 1'b0;
    if (clr) begin
      expected_nxt  = '0;
      good_nxt      = '0;
      err_count_nxt = '0;
    end else if (en) begin
      case (state)
        UNLOCKED: begin
          expected_nxt = pred_from_in;
          good_nxt     = '0;
        end
        ACQUIRE: begin
          if (match) begin
            expected_nxt = pred_from_exp;
            good_nxt     = good_inc;
          end else begin
            expected_nxt = pred_from_in;
            good_nxt     = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_nxt = pred_from_exp;
          end else begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = err_count_sat;
            expected_nxt  = pred_from_in;
            good_nxt      = '0;
          end
        end
        default: begin
          expected_nxt = '0;
          good_nxt     = '0;
        end
      endcase
    end
  end

  // Output registers; locked mirrors the state being entered so it is glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
      good_cnt  <= '0;
    end else begin
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_pulse_nxt;
      err_count <= err_count_nxt;
      expected  <= expected_nxt;
      good_cnt  <= good_nxt;
    end
  end

endmodule

// File: tb/tb_md_counter_checker_4bit.sv
// Purpose: scoreboard bench for md_counter_checker_4bit (default and 2-bit error counter instances).
// Latency: expectations are pushed when inputs are driven and popped one clock later at negedge.
// Backpressure: none; the monitor compares every cycle an expectation is pending.
module tb_md_counter_checker_4bit;

  localparam int LOCK = 2;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       en;
  logic       dir;
  logic [3:0] count_in;

  logic       locked_a, pulse_a;
  logic [7:0] errc_a;
  logic [3:0] exp_a;
  logic       locked_b, pulse_b;
  logic [1:0] errc_b;
  logic [3:0] exp_b;

  md_counter_checker_4bit dut_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .count_in(count_in),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(errc_a), .expected(exp_a)
  );

  md_counter_checker_4bit #(.ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .count_in(count_in),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(errc_b), .expected(exp_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit lk;
    bit pl;
    int ea;
    int eb;
    int ex;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: "have a reference value, and a run of consecutive matches since capture"
  int m_have, m_ref, m_streak, m_errs, m_pulse;
  int last_cnt;
  bit cur_dir;

  int dseq[6] = '{3, 2, 1, 0, 15, 14};
  int eseq[6] = '{4, 5, 6, 8, 9, 10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int nxt(input int v, input bit d);
    return d ? (v + 15) % 16 : (v + 1) % 16;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_have = 0; m_ref = 0; m_streak = 0; m_errs = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit c, input bit e, input bit d, input int v);
    if (c) begin
      model_reset();
    end else if (e) begin
      m_pulse = 0;
      if (m_have == 0) begin
        m_have = 1; m_ref = nxt(v, d); m_streak = 0;
      end else if (v == m_ref) begin
        m_ref = nxt(m_ref, d);
        m_streak++;
      end else begin
        if (m_streak >= LOCK) begin
          m_errs++;
          m_pulse = 1;
        end
        m_ref = nxt(v, d);
        m_streak = 0;
      end
    end else begin
      m_pulse = 0;
    end
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    s.lk = (m_streak >= LOCK);
    s.pl = (m_pulse != 0);
    s.ea = sat(m_errs, 255);
    s.eb = sat(m_errs, 3);
    s.ex = m_ref;
    return s;
  endfunction

  // Drive one sample mid-cycle, away from the rising edge, and queue what it should produce
  task automatic step(input bit c, input bit e, input bit d, input int v);
    @(negedge clk);
    #1;
    rst = 1'b1; clr = c; en = e; dir = d; count_in = v[3:0];
    model_step(c, e, d, v);
    sb.push_back(snapshot());
    last_cnt = v;
  endtask

  task automatic imm_reset_check(input string tag);
    chk({tag, "_locked"}, locked_a, 0);
    chk({tag, "_pulse"},  pulse_a,  0);
    chk({tag, "_errc_a"}, errc_a,   0);
    chk({tag, "_errc_b"}, errc_b,   0);
    chk({tag, "_exp"},    exp_a,    0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    imm_reset_check("async_rst");
    sb.push_back(snapshot());
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after they update
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("locked_a", locked_a, mon_e.lk);
      chk("pulse_a",  pulse_a,  mon_e.pl);
      chk("errc_a",   errc_a,   mon_e.ea);
      chk("exp_a",    exp_a,    mon_e.ex);
      chk("locked_b", locked_b, mon_e.lk);
      chk("pulse_b",  pulse_b,  mon_e.pl);
      chk("errc_b",   errc_b,   mon_e.eb);
      chk("exp_b",    exp_b,    mon_e.ex);
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; dir = 1'b0; count_in = 4'd0;
    last_cnt = 0; cur_dir = 1'b0;
    model_reset();
    #2;
    rst = 1'b0;
    #1;
    imm_reset_check("por");
    sb.push_back(snapshot());

    // Up stream with wrap 15->0
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, i % 16);

    // Down stream with wrap 0->15, ending with expected 13
    step(1'b1, 1'b0, 1'b0, 0);
    foreach (dseq[i]) step(1'b0, 1'b1, 1'b1, dseq[i]);

    // Locked up stream with one injected glitch
    step(1'b1, 1'b0, 1'b0, 0);
    foreach (eseq[i]) step(1'b0, 1'b1, 1'b0, eseq[i]);

    // Repeated lock-then-glitch: 2-bit counter saturates at 3
    step(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, (k * 3) % 16);
      step(1'b0, 1'b1, 1'b0, (k * 3 + 1) % 16);
      step(1'b0, 1'b1, 1'b0, (k * 3 + 2) % 16);
      step(1'b0, 1'b1, 1'b0, (k * 3 + 7) % 16);
    end
    step(1'b1, 1'b0, 1'b0, 0);

    // Lock at 9, then asynchronous reset between edges, then fresh stream
    step(1'b0, 1'b1, 1'b0, 7);
    step(1'b0, 1'b1, 1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 9);
    async_reset();
    step(1'b0, 1'b1, 1'b0, 2);
    step(1'b0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b1, 1'b0, 4);

    // Enable gaps: garbage while en=0 is ignored
    step(1'b0, 1'b1, 1'b0, 5);
    step(1'b0, 1'b0, 1'b0, $urandom_range(0, 15));
    step(1'b0, 1'b0, 1'b0, $urandom_range(0, 15));
    step(1'b0, 1'b1, 1'b0, 6);

    // Direction change while locked: one error, then relock downward
    step(1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b1, 4);
    step(1'b0, 1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1'b1, 2);

    // clr beats en with a mismatching value
    step(1'b1, 1'b1, 1'b0, 12);

    // Randomised stream: mostly well-behaved counting with occasional faults
    cur_dir = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit c, e;
      int v;
      c = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) cur_dir = ~cur_dir;
      if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 15);
      else                           v = nxt(last_cnt, cur_dir);
      step(c, e, cur_dir, v);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
